// File: rtl/product_accumulator.sv
// Signed MAC accumulator: sums N_TERMS signed 8-bit products per frame behind valid/ready handshakes.
// Optional build macro PRODUCT_ACC_SAT_EN selects saturating arithmetic; default wraps modulo 2^ACC_W.
module product_accumulator #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next, ext, sum;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf, ovf_next, add_ovf;

  assign ext     = ACC_W'($signed(product));
  assign sum     = acc + ext;
  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // Handshake outputs decode only registered state, so no input-to-output paths.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;
  assign overflow  = ovf;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    unique case (state)
      IDLE: state_next = ACCUM;
      ACCUM: begin
        if (in_valid) begin
`ifdef PRODUCT_ACC_SAT_EN
          acc_next = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
          acc_next = sum;
`endif
          cnt_next = cnt + 1'b1;
          ovf_next = ovf | add_ovf;
          if (cnt == LAST) state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over any handshake in the same cycle; the product is dropped.
    if (clear) begin
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
      state_next = ACCUM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 16-bit and an 8-bit accumulator share stimulus; a negedge monitor checks results.
module tb_product_accumulator;

  logic        clk, rst, clear, in_valid, out_ready;
  logic [7:0]  product;
  logic        in_ready, out_valid, overflow;
  logic [15:0] acc_out;
  logic        in_ready8, out_valid8, overflow8;
  logic [7:0]  acc_out8;

  product_accumulator #(.ACC_W(16), .N_TERMS(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow)
  );

  product_accumulator #(.ACC_W(8), .N_TERMS(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .product(product), .out_valid(out_valid8), .out_ready(out_ready),
    .acc_out(acc_out8), .overflow(overflow8)
  );

  typedef struct {
    longint acc16;
    bit     ovf16;
    longint acc8;
    bit     ovf8;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   expect_ready_next = 0;
  logic signed [7:0] vec [8];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (expect_ready_next) begin
        check("in_ready_after_result", longint'(in_ready), 1);
        check("out_valid_one_cycle", longint'(out_valid), 0);
        expect_ready_next = 0;
      end
      if (out_valid || out_valid8) begin
        check("out_valid_8_vs_16", longint'(out_valid8), longint'(out_valid));
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", longint'(out_valid), 0);
        end else begin
          check("acc_out_16", longint'($signed(acc_out)), exp_q[0].acc16);
          check("overflow_16", longint'(overflow), longint'(exp_q[0].ovf16));
          check("acc_out_8", longint'($signed(acc_out8)), exp_q[0].acc8);
          check("overflow_8", longint'(overflow8), longint'(exp_q[0].ovf8));
          if (out_ready) begin
            void'(exp_q.pop_front());
            expect_ready_next = 1;
          end else begin
            check("in_ready_during_stall", longint'(in_ready), 0);
          end
        end
      end
    end
  end

  task automatic send(input logic signed [7:0] p, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 0;
      @(posedge clk); #1;
    end
    in_valid = 1;
    product  = p;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] gaps, input longint a16, input bit o16,
                            input longint a8, input bit o8);
    exp_t e;
    e.acc16 = a16; e.ovf16 = o16; e.acc8 = a8; e.ovf8 = o8;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(e);
      send(vec[i], gaps[i]);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("result_timeout", longint'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_overflow", longint'(overflow), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    check("accum_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic load(input int a0, a1, a2, a3, a4, a5, a6, a7);
    vec[0] = 8'(a0); vec[1] = 8'(a1); vec[2] = 8'(a2); vec[3] = 8'(a3);
    vec[4] = 8'(a4); vec[5] = 8'(a5); vec[6] = 8'(a6); vec[7] = 8'(a7);
  endtask

  initial begin
    clear = 0; in_valid = 0; product = '0; out_ready = 1;
    do_reset();

    // Basic frame, back-to-back.
    load(6, 15, 1, -4, -49, 12, 10, 64);
    send_frame(8'h00, 55, 0, 55, 0);
    wait_drain();

    // Input gaps plus five cycles of output backpressure.
    out_ready = 0;
    send_frame(8'b1001_1010, 55, 0, 55, 0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    wait_drain();

    // Clear mid-frame discards the partial sum and the coincident product.
    send(64, 0); send(64, 0); send(64, 0);
    clear = 1; in_valid = 1; product = 8'd10;
    @(posedge clk); #1;
    clear = 0; in_valid = 0;
    load(-1, -1, -1, -1, -1, -1, -1, -1);
    send_frame(8'h00, -8, 0, -8, 0);
    wait_drain();

    // Positive overflow of the 8-bit instance.
    load(64, 64, 64, 64, 64, 64, 64, 64);
`ifdef PRODUCT_ACC_SAT_EN
    send_frame(8'h00, 512, 0, 127, 1);
`else
    send_frame(8'h00, 512, 0, 0, 1);
`endif
    wait_drain();

    // Negative overflow of the 8-bit instance.
    load(-56, -56, -56, -56, -56, -56, -56, -56);
`ifdef PRODUCT_ACC_SAT_EN
    send_frame(8'h00, -448, 0, -128, 1);
`else
    send_frame(8'h00, -448, 0, 64, 1);
`endif
    wait_drain();

    // Asynchronous reset after four products, asserted between edges.
    send(20, 0); send(30, 0); send(-40, 0); send(50, 0);
    #2;
    do_reset();
    load(10, -20, 30, -40, 50, -56, 64, 7);
    send_frame(8'b0010_0100, 45, 0, 45, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential signed accumulator directly downstream of the 4-bit signed multiplier. It consumes one signed 8-bit product per valid/ready handshake and sums `N_TERMS` products into a dot-product result. It presents the result on an output valid/ready handshake, then clears itself for the next frame. This is the stage that turns per-pair products into a MAC result.

## Interface
- `ACC_W`, default 16: accumulator and result width in bits; legal range 8..32.
- `N_TERMS`, default 8: number of products per frame; legal range 2..256.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous frame abort; discards the running sum.
- `in_valid` input 1: `product` is valid.
- `in_ready` output 1: block accepts a product this cycle.
- `product` input 8: signed two's-complement product (range -56..64 from the 4-bit multiplier).
- `out_valid` output 1: `acc_out` holds a completed frame sum.
- `out_ready` input 1: downstream accepts the result.
- `acc_out` output ACC_W: signed accumulator value.
- `overflow` output 1: sticky per frame; set if any addition in the frame exceeded the ACC_W signed range.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- Reset state is IDLE. Reset values: `acc_out`=0, `overflow`=0, `out_valid`=0, `in_ready`=0, term counter=0.
- **IDLE**
  - `in_ready`=0.
  - Unconditional move to ACCUM on the next edge.
- **ACCUM**
  - `in_ready`=1.
  - On `in_valid & in_ready`: acc <= acc + sign_extend(product, ACC_W), and the counter increments.
  - If the counter equals N_TERMS-1 at that handshake, move to DONE.
- **DONE**
  - `in_ready`=0, `out_valid`=1.
  - `acc_out` and `overflow` are held stable until `out_ready`.
  - On `out_valid & out_ready`: acc, counter and overflow clear to 0, and the FSM returns to ACCUM.
- **Arithmetic**
  - Signed addition at ACC_W.
  - Overflow is detected when both operands have the same sign and the sum's sign differs.
- **`clear`**
  - Priority: above everything except `rst`.
  - In any state it zeroes acc, counter and overflow, drops `out_valid`, and moves the FSM to ACCUM.
  - A product handshaken in the same cycle as `clear` is discarded; upstream treats it as consumed.
- `acc_out` continuously shows the running sum; it is meaningful to downstream only while `out_valid`=1.
- **Mid-frame `rst`:** all state clears immediately. The partial sum is lost and no result is emitted.

## Timing
- Products are accepted at up to 1 per cycle in ACCUM.
- `out_valid` rises in the cycle after the edge that accepts the N_TERMS-th product.
- **Throughput:** N_TERMS+1 cycles per frame when `out_ready` is held high, because the DONE handshake is one cycle.
- **Backpressure:**
  - `in_valid` low in ACCUM stalls without changing state.
  - `out_ready` low in DONE holds indefinitely.
- First `in_ready`=1 is one cycle after `rst` deasserts, because IDLE lasts one cycle.
- All outputs are registered or decoded from registered state only. No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.

## Configuration
- Macro: `PRODUCT_ACC_SAT_EN`.
- **Defined:** on overflow, acc saturates to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) according to the direction of overflow. Once saturated, later additions continue from the saturated value.
- **Undefined:** acc wraps modulo 2^ACC_W.
- In both builds `overflow` is set identically.

## Test plan
- **Basic frame:** defaults; feed products 6, 15, 1, -4, -49, 12, 10, 64 back-to-back with `out_ready`=1. Required: `out_valid` is high for 1 cycle with `acc_out`=55 and `overflow`=0; `in_ready` returns high on the next cycle.
- **Input gaps and output backpressure:** same products with `in_valid` deasserted on random cycles, and `out_ready` held low for 5 cycles after `out_valid` rises. Required: `acc_out`=55 held stable and `in_ready`=0 throughout the stall. The next frame starts from 0.
- **Clear mid-frame:** feed 3 products (64, 64, 64), assert `clear` with `in_valid`=1 and `product`=10, then feed 8× (-1). Required: `acc_out`=-8 with no intermediate `out_valid`.
- **Saturation build:** ACC_W=8 with `PRODUCT_ACC_SAT_EN`.
  - 8×64 → `acc_out`=127, `overflow`=1.
  - 8×(-56) → `acc_out`=-128, `overflow`=1.
- **Wrap build:** ACC_W=8 without the macro; 8×64 → `acc_out`=0, `overflow`=1.
- **Async reset:** assert `rst` mid-frame (after 4 products) between clock edges. Required:
  - All outputs go to 0 immediately.
  - `in_ready` is 0 for one cycle after release, then 1.
  - A fresh 8-product frame sums correctly.
